// File: rtl/swap_req_scheduler_if.sv
// Request/issue/status bundle between a swap-request producer, the swap FSM
// and swap_req_scheduler. The slave modport is the scheduler's view.
interface swap_req_scheduler_if #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr_a;
  logic [ADDR_W-1:0] req_addr_b;
  logic              swap;
  logic              fsm_w;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              busy;
  logic [LVL_W-1:0]  level;
  logic              done;
  logic [CNT_W-1:0]  done_cnt;
  logic              err;

  modport master (
    output req_valid, req_addr_a, req_addr_b, fsm_w,
    input  req_ready, swap, addr_a, addr_b, busy, level, done, done_cnt, err
  );

  modport slave (
    input  req_valid, req_addr_a, req_addr_b, fsm_w,
    output req_ready, swap, addr_a, addr_b, busy, level, done, done_cnt, err
  );
endinterface

// File: rtl/swap_req_scheduler.sv
// Queues swap requests and issues them one at a time to the memory-swap FSM.
// Optional SWAP_SKIP_SAME_EN: requests with addr_a == addr_b are dropped in IDLE.
module swap_req_scheduler #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  swap_req_scheduler_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a queued request while the swap FSM is idle
  // ISSUE | swap pulse is high this cycle
  // ARM   | expecting the swap FSM to have left idle (fsm_w high)
  // RUN   | swap FSM busy; completion on fsm_w falling
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ARM   = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [ADDR_W-1:0] r_mem_a [DEPTH];
  logic [ADDR_W-1:0] r_mem_b [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  state_t            r_state;
  logic              r_swap;
  logic              r_done;
  logic              r_err;
  logic [CNT_W-1:0]  r_done_cnt;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;

  logic              w_full;
  logic              w_nonempty;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_err_set;
  logic              w_done_set;
  logic [ADDR_W-1:0] w_head_a;
  logic [ADDR_W-1:0] w_head_b;
  state_t            w_state_nxt;

  // Full is judged on the registered level only: a same-cycle pop never frees a slot.
  assign w_full     = (r_level == LVL_FULL);
  assign w_nonempty = (r_level != '0);
  assign w_push     = bus.req_valid && !w_full;
  assign w_head_a   = r_mem_a[r_rd_ptr];
  assign w_head_b   = r_mem_b[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= bus.req_addr_a;
      r_mem_b[r_wr_ptr] <= bus.req_addr_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_err_set   = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty && !bus.fsm_w) begin
          w_pop = 1'b1;
`ifdef SWAP_SKIP_SAME_EN
          if (w_head_a != w_head_b) begin
            w_load      = 1'b1;
            w_state_nxt = S_ISSUE;
          end
`else
          w_load      = 1'b1;
          w_state_nxt = S_ISSUE;
`endif
        end
      end
      S_ISSUE: w_state_nxt = S_ARM;
      S_ARM: begin
        if (bus.fsm_w) begin
          w_state_nxt = S_RUN;
        end else begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (!bus.fsm_w) begin
          w_done_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_swap     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_done_cnt <= '0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
    end else begin
      r_swap <= (w_state_nxt == S_ISSUE);
      r_done <= w_done_set;
      if (w_err_set)  r_err      <= 1'b1;
      if (w_done_set) r_done_cnt <= r_done_cnt + CNT_W'(1);
      if (w_load) begin
        r_addr_a <= w_head_a;
        r_addr_b <= w_head_b;
      end
    end
  end

  assign bus.req_ready = !w_full;
  assign bus.swap      = r_swap;
  assign bus.addr_a    = r_addr_a;
  assign bus.addr_b    = r_addr_b;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.level     = r_level;
  assign bus.done      = r_done;
  assign bus.done_cnt  = r_done_cnt;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_swap_req_scheduler.sv
// Bench for swap_req_scheduler: a small swap-FSM emulator drives fsm_w and a
// timestamp-based transaction model predicts every output each cycle.
module tb_swap_req_scheduler;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int BIG    = 1 << 30;
`ifdef SWAP_SKIP_SAME_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  swap_req_scheduler_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  swap_req_scheduler #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  // swap-FSM emulator: 0 = responds to swap, 1 = forced busy, 2 = never starts
  int w_mode  = 0;
  int emu_cnt = 0;
  int emu_len = 3;

  // reference model: FIFO contents plus timestamps of scheduler events
  logic [5:0] mq[$];
  logic [5:0] m_addr;
  logic [7:0] m_cnt;
  bit         m_err;
  bit         m_run;
  int         m_free_at, m_pop_at, m_done_at;

  logic [21:0] obs_v, exp_v;

  task automatic model_reset();
    mq.delete();
    m_addr = '0; m_cnt = '0; m_err = 1'b0; m_run = 1'b0;
    m_free_at = 0; m_pop_at = -100; m_done_at = -100;
    emu_cnt = 0; w_mode = 0;
  endtask

  task automatic observe();
    exp_v = {(mq.size() < DEPTH), (cyc == m_pop_at + 1), (cyc < m_free_at),
             (cyc == m_done_at), m_err, 3'(mq.size()), m_addr, m_cnt};
    obs_v = {bus.req_ready, bus.swap, bus.busy, bus.done, bus.err, bus.level,
             bus.addr_a, bus.addr_b, bus.done_cnt};
  endtask

  // Drive one cycle's inputs, advance the model, move to the next mid-cycle point.
  task automatic advance(input bit v, input logic [2:0] a, input logic [2:0] b);
    logic [5:0] head;
    int         sz;
    bit         pushed;
    bit         w;
    if (w_mode == 1)      w = 1'b1;
    else if (w_mode == 2) w = 1'b0;
    else if (emu_cnt > 0) begin w = 1'b1; emu_cnt--; end
    else                  w = 1'b0;
    if (bus.swap === 1'b1 && w_mode == 0) emu_cnt = emu_len;
    bus.req_valid  = v;
    bus.req_addr_a = a;
    bus.req_addr_b = b;
    bus.fsm_w      = w;
    sz     = mq.size();
    pushed = v && (sz < DEPTH);
    if (cyc >= m_free_at && sz > 0 && !w) begin
      head = mq.pop_front();
      if (!(SKIP && head[5:3] == head[2:0])) begin
        m_addr = head; m_pop_at = cyc; m_free_at = BIG; m_run = 1'b0;
      end
    end else if (cyc == m_pop_at + 2 && m_free_at == BIG) begin
      if (!w) begin m_err = 1'b1; m_free_at = cyc + 1; end
      else m_run = 1'b1;
    end else if (m_run && !w) begin
      m_done_at = cyc + 1; m_cnt = m_cnt + 8'd1; m_free_at = cyc + 1; m_run = 1'b0;
    end
    if (pushed) mq.push_back({a, b});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr_a = '0; bus.req_addr_b = '0; bus.fsm_w = 1'b0;
    model_reset();
    #2;
    observe();
    vec++;
    if (obs_v !== 22'h200000) begin
      miss++; $display("FAIL reset_state got=%h exp=%h", obs_v, 22'h200000);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      observe(); vec++;
      if (obs_v !== exp_v) begin
        miss++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      advance(1'b0, 3'd0, 3'd0);
    end
  endtask

  task automatic test_single();
    int swap_c = -1;
    int done_c = -1;
    emu_len = 3;
    for (int i = 0; i < 12; i++) begin
      observe(); vec++;
      if (obs_v !== exp_v) begin
        miss++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (bus.swap === 1'b1) begin
        swap_c = cyc; vec++;
        if (bus.addr_a !== 3'd1 || bus.addr_b !== 3'd5) begin
          miss++; $display("FAIL single_addr got=%0d,%0d exp=1,5", bus.addr_a, bus.addr_b);
        end
      end
      if (bus.done === 1'b1) done_c = cyc;
      advance(i == 0, 3'd1, 3'd5);
    end
    vec++;
    if (swap_c < 0 || done_c - swap_c != 5) begin
      miss++; $display("FAIL single_latency got swap=%0d done=%0d exp done-swap=5", swap_c, done_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cnt0 = m_cnt;
    emu_len = 3;
    for (int i = 0; i < 45; i++) begin
      observe(); vec++;
      if (obs_v !== exp_v) begin
        miss++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (i == 5) begin
        vec++;
        if (bus.req_ready !== 1'b0) begin
          miss++; $display("FAIL b2b_full got ready=%b exp=0", bus.req_ready);
        end
      end
      advance(i < 6, 3'(i), 3'(7 - i));
    end
    vec++;
    if (bus.level !== 3'd0 || bus.done_cnt !== cnt0 + 8'd5) begin
      miss++; $display("FAIL b2b_drain got level=%0d cnt=%0d exp level=0 cnt=%0d",
                       bus.level, bus.done_cnt, cnt0 + 8'd5);
    end
  endtask

  task automatic test_hold_w();
    emu_len = 2;
    w_mode = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) w_mode = 0;
      observe(); vec++;
      if (obs_v !== exp_v) begin
        miss++; $display("FAIL hold_w cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (i == 5) begin
        vec++;
        if (bus.busy !== 1'b0 || bus.level !== 3'd1) begin
          miss++; $display("FAIL hold_w_nopop got busy=%b level=%0d exp busy=0 level=1",
                           bus.busy, bus.level);
        end
      end
      advance(i == 0, 3'd6, 3'd2);
    end
  endtask

  task automatic test_stuck_low();
    logic [7:0] cnt0 = m_cnt;
    w_mode = 2;
    for (int i = 0; i < 8; i++) begin
      observe(); vec++;
      if (obs_v !== exp_v) begin
        miss++; $display("FAIL stuck cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      advance(i == 0, 3'd4, 3'd0);
    end
    vec++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done_cnt !== cnt0) begin
      miss++; $display("FAIL stuck_err got err=%b busy=%b cnt=%0d exp err=1 busy=0 cnt=%0d",
                       bus.err, bus.busy, bus.done_cnt, cnt0);
    end
    w_mode = 0;
  endtask

  task automatic test_reset_mid();
    emu_len = 3;
    for (int i = 0; i < 6; i++) begin
      observe(); vec++;
      if (obs_v !== exp_v) begin
        miss++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      advance(i < 3, 3'(i + 1), 3'(i + 4));
    end
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.fsm_w = 1'b0;
    model_reset();
    #1;
    vec++;
    if ({bus.req_ready, bus.swap, bus.busy, bus.done, bus.err, bus.level,
         bus.addr_a, bus.addr_b, bus.done_cnt} !== 22'h200000) begin
      miss++; $display("FAIL mid_reset got ready=%b busy=%b level=%0d cnt=%0d err=%b exp 1,0,0,0,0",
                       bus.req_ready, bus.busy, bus.level, bus.done_cnt, bus.err);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      observe(); vec++;
      if (obs_v !== exp_v) begin
        miss++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      advance(1'b0, 3'd0, 3'd0);
    end
  endtask

  task automatic test_skip_same();
    logic [7:0] cnt0 = m_cnt;
    logic [7:0] want;
    emu_len = 3;
    for (int i = 0; i < 22; i++) begin
      observe(); vec++;
      if (obs_v !== exp_v) begin
        miss++; $display("FAIL skip cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      advance(i < 2, (i == 0) ? 3'd3 : 3'd2, (i == 0) ? 3'd3 : 3'd6);
    end
    want = cnt0 + (SKIP ? 8'd1 : 8'd2);
    vec++;
    if (bus.done_cnt !== want) begin
      miss++; $display("FAIL skip_cnt got=%0d exp=%0d", bus.done_cnt, want);
    end
  endtask

  task automatic test_random();
    logic [2:0] a, b;
    for (int i = 0; i < 600; i++) begin
      observe(); vec++;
      if (obs_v !== exp_v) begin
        miss++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      emu_len = $urandom_range(1, 4);
      a = 3'($urandom_range(0, 7));
      b = ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7));
      advance($urandom_range(0, 2) != 0, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_w();
    test_stuck_low();
    test_reset_mid();
    test_skip_same();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/swap_req_scheduler.md
Name: swap_req_scheduler

Overview:
- Upstream feeder for the memory-swap controller FSM.
- Queues swap requests, each a pair of register-file addresses, in a small FIFO with a valid/ready interface.
- Issues one request at a time: presents the address pair to the swapper datapath and pulses the FSM's `swap` input.
- Tracks the FSM's write-enable (`w`) to detect completion, then reports `done` and a completion count.

Parameters:
- ADDR_W, 3, width of each swap address.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_W, 8, width of the completed-swap counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; high when level < DEPTH.
- req_addr_a  in  ADDR_W  first location of the request.
- req_addr_b  in  ADDR_W  second location of the request.
- swap  out  1  one-cycle start pulse to the swap FSM.
- fsm_w  in  1  swap FSM write-enable; high while the FSM is not idle.
- addr_a  out  ADDR_W  address A for the active swap, held stable.
- addr_b  out  ADDR_W  address B for the active swap, held stable.
- busy  out  1  scheduler state ≠ IDLE.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- done  out  1  one-cycle pulse per completed swap.
- done_cnt  out  CNT_W  completed swaps; wraps modulo 2^CNT_W.
- err  out  1  sticky; FSM failed to start after `swap`.

Behaviour:
- Reset: asynchronous clear of every output, FIFO pointers and state.
  - req_ready = 1.
  - All other outputs = 0.
- FIFO:
  - Push on req_valid && req_ready.
  - Read/write pointers wrap modulo DEPTH.
  - req_ready is low when full, even if a pop occurs in the same cycle; there is no bypass.
  - Simultaneous push and pop leave level unchanged.
- State machine (Moore; swap and done registered):
  - IDLE: if level > 0 and fsm_w == 0, then pop the head, load addr_a/addr_b, and go to ISSUE. Otherwise stay. No pop while fsm_w == 1.
  - ISSUE: swap = 1 for exactly this cycle; go to ARM.
  - ARM:
    - If fsm_w == 1, go to RUN.
    - If fsm_w == 0, set err and go to IDLE without asserting done.
  - RUN: stay while fsm_w == 1. When fsm_w == 0, go to IDLE, assert done in the following cycle, and increment done_cnt.
- Timing, with the FSM running 3 non-idle cycles:
  - pop at T0, swap at T1, FSM busy T2–T4, FSM idle at T5, done at T6.
  - The next pop is possible at T6.
  - Sustained throughput: one swap per 6 cycles.
- addr_a/addr_b change only on a pop; they hold after completion.
- err clears only on reset.
- Reset mid-operation: FIFO is flushed, state → IDLE, swap deasserts immediately. The FSM is reset by the same reset_n.

Optional Feature:
- Macro: SWAP_SKIP_SAME_EN.
- Defined: in IDLE, a head entry with addr_a == addr_b is popped and discarded in one cycle.
  - State stays IDLE.
  - swap, done and done_cnt are not affected.
  - addr_a/addr_b are not updated.
  - The next entry may be examined the following cycle.
- Undefined: such requests are issued like any other.

Test Plan:
- Reset, push (1,5) -> swap at T1, addr_a=1, addr_b=5; done at T6; done_cnt=1; busy high T1–T5.
- Push 4 requests back-to-back with the FSM idle -> req_ready low after the 4th, or after the 5th if the first pop overlaps; all 4 complete in order; done_cnt=4; level returns to 0.
- Hold fsm_w=1 externally with 1 entry queued -> no pop and no swap until fsm_w drops; then normal sequence.
- fsm_w stuck at 0 after swap -> err=1 in the cycle after ARM, no done, state IDLE, done_cnt unchanged.
- Assert reset_n low during RUN with 2 entries queued -> all outputs 0, level=0, req_ready=1; no done after reset release.
- With SWAP_SKIP_SAME_EN defined, queue (3,3),(2,6) -> (3,3) dropped with no swap; (2,6) swap pulse 1 cycle later than otherwise; done_cnt=1. Without the macro: 2 swaps, done_cnt=2.
